// File: rtl/arcade_input_mapper_if.sv
// Cabinet input bus for arcade_input_mapper.
// The master side drives the PS/2 key word, both joysticks and the mode
// controls; the slave side (the mapper) returns the two registered button
// vectors.
interface arcade_input_mapper_if #(
    parameter int NUM_KEYS = 6
);
    logic [10:0]         ps2_key;
    logic [15:0]         joystick_0;
    logic [15:0]         joystick_1;
    logic                cocktail;
    logic                autofire_on;
    logic [NUM_KEYS-1:0] btn_p1;
    logic [NUM_KEYS-1:0] btn_p2;

    modport master (
        output ps2_key,
        output joystick_0,
        output joystick_1,
        output cocktail,
        output autofire_on,
        input  btn_p1,
        input  btn_p2
    );

    modport slave (
        input  ps2_key,
        input  joystick_0,
        input  joystick_1,
        input  cocktail,
        input  autofire_on,
        output btn_p1,
        output btn_p2
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: table-driven PS/2 key decode merged with joystick
// bits, single-stick or cocktail routing, and a coin pulse shaper with
// lockout so the core sees exactly one coin per insertion.
// Optional build macro AUTOFIRE_EN adds a square-wave autofire on the fire
// button of each player; without it autofire_on is ignored.
module arcade_input_mapper #(
    parameter int                    NUM_KEYS       = 6,
    parameter logic [9*NUM_KEYS-1:0] KEY_TABLE      = {9'h021, 9'h023, 9'h01C,
                                                       9'h006, 9'h005, 9'h029},
    parameter logic [5*NUM_KEYS-1:0] JOY_MAP        = {5'd8, 5'd0, 5'd1,
                                                       5'd31, 5'd8, 5'd5},
    parameter int                    COIN_IDX       = 5,
    parameter int                    COIN_PULSE_CYC = 8,
    parameter int                    COIN_GAP_CYC   = 8
`ifdef AUTOFIRE_EN
    ,
    parameter int                    FIRE_IDX       = 0,
    parameter int                    AUTOFIRE_HALF  = 4
`endif
) (
    input  logic                 Clk,
    input  logic                 I_RESET,
    arcade_input_mapper_if.slave bus
);

    localparam logic [NUM_KEYS-1:0] ONE_HOT    = {{(NUM_KEYS-1){1'b0}}, 1'b1};
    localparam logic [NUM_KEYS-1:0] COIN_MASK  = ONE_HOT << COIN_IDX;
    localparam logic [15:0]         PULSE_LOAD = 16'(COIN_PULSE_CYC - 1);
    localparam logic [15:0]         GAP_LOAD   = 16'(COIN_GAP_CYC - 1);

`ifdef AUTOFIRE_EN
    localparam logic [NUM_KEYS-1:0] FIRE_MASK    = ONE_HOT << FIRE_IDX;
    localparam logic [NUM_KEYS-1:0] SPECIAL_MASK = COIN_MASK | FIRE_MASK;
    localparam logic [15:0]         AF_LOAD      = 16'(AUTOFIRE_HALF - 1);
`else
    localparam logic [NUM_KEYS-1:0] SPECIAL_MASK = COIN_MASK;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    logic [NUM_KEYS-1:0] key_state;
    logic                old_toggle;
    logic [NUM_KEYS-1:0] raw_p1;
    logic [NUM_KEYS-1:0] raw_p2;
    logic [4:0]          joy_idx;
    logic [NUM_KEYS-1:0] btn_p1_q;
    logic [NUM_KEYS-1:0] btn_p2_q;
    logic                coin_src;
    logic                coin_prev;
    logic                coin_out;
    logic [15:0]         coin_cnt;
    coin_state_t         coin_state;

    // A key event is a change of the PS/2 toggle bit; every matching table entry takes the pressed flag.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            key_state  <= '0;
            old_toggle <= bus.ps2_key[10];
        end else begin
            old_toggle <= bus.ps2_key[10];
            if (bus.ps2_key[10] != old_toggle) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEY_TABLE[9*i +: 9] == bus.ps2_key[8:0]) begin
                        key_state[i] <= bus.ps2_key[9];
                    end
                end
            end
        end
    end

    // Merge keyboard state with the mapped joystick bit; joystick_1 goes to P1 or P2 depending on cocktail mode.
    always_comb begin
        raw_p1  = '0;
        raw_p2  = '0;
        joy_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            joy_idx   = JOY_MAP[5*i +: 5];
            raw_p1[i] = key_state[i];
            if (!joy_idx[4]) begin
                raw_p1[i] = key_state[i] | bus.joystick_0[joy_idx[3:0]]
                          | (~bus.cocktail & bus.joystick_1[joy_idx[3:0]]);
                raw_p2[i] = bus.cocktail & bus.joystick_1[joy_idx[3:0]];
            end
        end
    end

    assign coin_src = raw_p1[COIN_IDX] | raw_p2[COIN_IDX];

    // Plain buttons are registered straight from the merge; coin (and fire with autofire) come from their own logic.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            btn_p1_q <= '0;
            btn_p2_q <= '0;
        end else begin
            btn_p1_q <= raw_p1 & ~SPECIAL_MASK;
            btn_p2_q <= raw_p2 & ~SPECIAL_MASK;
        end
    end

    // Coin shaper: a rising edge in IDLE starts a fixed pulse followed by a forced-low gap; coin_prev resets high so a held source needs a fresh press.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            coin_state <= IDLE;
            coin_cnt   <= '0;
            coin_out   <= 1'b0;
            coin_prev  <= 1'b1;
        end else begin
            coin_prev <= coin_src;
            case (coin_state)
                IDLE: begin
                    if (coin_src && !coin_prev) begin
                        coin_state <= PULSE;
                        coin_cnt   <= PULSE_LOAD;
                        coin_out   <= 1'b1;
                    end else begin
                        coin_out   <= 1'b0;
                    end
                end
                PULSE: begin
                    if (coin_cnt == 16'd0) begin
                        coin_state <= GAP;
                        coin_cnt   <= GAP_LOAD;
                        coin_out   <= 1'b0;
                    end else begin
                        coin_cnt   <= coin_cnt - 16'd1;
                        coin_out   <= 1'b1;
                    end
                end
                GAP: begin
                    coin_out <= 1'b0;
                    if (coin_cnt == 16'd0) begin
                        coin_state <= IDLE;
                    end else begin
                        coin_cnt   <= coin_cnt - 16'd1;
                    end
                end
                default: begin
                    coin_state <= IDLE;
                    coin_out   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUTOFIRE_EN
    logic [1:0]  af_out;
    logic [1:0]  af_active;
    logic [15:0] af_cnt [2];
    logic [1:0]  fire_raw;

    assign fire_raw = {raw_p2[FIRE_IDX], raw_p1[FIRE_IDX]};

    // Per-player autofire: first held cycle is high, then the level flips every AUTOFIRE_HALF cycles; release restarts the phase.
    always_ff @(posedge Clk) begin
        if (I_RESET) begin
            af_out    <= '0;
            af_active <= '0;
            af_cnt[0] <= '0;
            af_cnt[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!fire_raw[p]) begin
                    af_active[p] <= 1'b0;
                    af_out[p]    <= 1'b0;
                end else if (!bus.autofire_on) begin
                    af_active[p] <= 1'b0;
                    af_out[p]    <= 1'b1;
                end else if (!af_active[p]) begin
                    af_active[p] <= 1'b1;
                    af_out[p]    <= 1'b1;
                    af_cnt[p]    <= AF_LOAD;
                end else if (af_cnt[p] == 16'd0) begin
                    af_out[p]    <= ~af_out[p];
                    af_cnt[p]    <= AF_LOAD;
                end else begin
                    af_cnt[p]    <= af_cnt[p] - 16'd1;
                end
            end
        end
    end

    assign bus.btn_p1 = btn_p1_q | (coin_out ? COIN_MASK : '0)
                      | (af_out[0] ? FIRE_MASK : '0);
    assign bus.btn_p2 = btn_p2_q | (af_out[1] ? FIRE_MASK : '0);
`else
    logic unused_autofire;
    assign unused_autofire = bus.autofire_on;

    assign bus.btn_p1 = btn_p1_q | (coin_out ? COIN_MASK : '0);
    assign bus.btn_p2 = btn_p2_q;
`endif

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper with the default parameter
// set. A behavioural model tracks pressed keys, joystick routing, the coin
// pulse window and (with AUTOFIRE_EN) the autofire square wave; directed
// steps and a randomized phase are checked against it every cycle.
module tb_arcade_input_mapper;

    localparam int HALF = 4;

    logic clk;
    logic rst;

    arcade_input_mapper_if #(.NUM_KEYS(6)) bus ();

    arcade_input_mapper dut (
        .Clk     (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Logical button table: fire, 1P, 2P, left, right, coin.
    int key_code [6] = '{'h029, 'h005, 'h006, 'h01C, 'h023, 'h021};
    int joy_bit  [6] = '{5, 8, 31, 1, 0, 8};

    // Reference model state.
    bit          model_keys [6];
    bit          m_old_tog = 1'b0;
    bit          m_coin_last = 1'b1;
    bit          m_src;
    bit          m_fire;
    longint      m_cyc = 0;
    longint      m_pulse_start = -100;
    longint      m_busy_until = 0;
    int          m_af_run [2] = '{0, 0};
    logic [5:0]  m_r1;
    logic [5:0]  m_r2;
    logic [5:0]  exp_p1 = '0;
    logic [5:0]  exp_p2 = '0;

    bit tog_state = 1'b0;

    // Model: expected buttons after each edge, from the keys held before it and the inputs at it.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            m_r1[i] = model_keys[i];
            m_r2[i] = 1'b0;
            if (joy_bit[i] < 16) begin
                m_r1[i] = model_keys[i] | bus.joystick_0[joy_bit[i]]
                        | (!bus.cocktail && bus.joystick_1[joy_bit[i]]);
                m_r2[i] = bus.cocktail && bus.joystick_1[joy_bit[i]];
            end
        end
        if (rst) begin
            for (int i = 0; i < 6; i++) model_keys[i] = 1'b0;
            m_old_tog     = bus.ps2_key[10];
            m_coin_last   = 1'b1;
            m_pulse_start = -100;
            m_busy_until  = 0;
            m_af_run[0]   = 0;
            m_af_run[1]   = 0;
            exp_p1        = '0;
            exp_p2        = '0;
        end else begin
            m_src = m_r1[5] | m_r2[5];
            if (m_src && !m_coin_last && m_cyc >= m_busy_until) begin
                m_pulse_start = m_cyc;
                m_busy_until  = m_cyc + 17;
            end
            m_coin_last = m_src;
            exp_p1    = m_r1;
            exp_p2    = m_r2;
            exp_p1[5] = (m_cyc >= m_pulse_start) && (m_cyc < m_pulse_start + 8);
            exp_p2[5] = 1'b0;
`ifdef AUTOFIRE_EN
            for (int p = 0; p < 2; p++) begin
                m_fire = (p == 0) ? m_r1[0] : m_r2[0];
                if (m_fire && bus.autofire_on) begin
                    m_fire = ((m_af_run[p] / HALF) % 2) == 0;
                    m_af_run[p]++;
                end else begin
                    m_af_run[p] = 0;
                end
                if (p == 0) exp_p1[0] = m_fire;
                else        exp_p2[0] = m_fire;
            end
`endif
            if (bus.ps2_key[10] != m_old_tog) begin
                for (int i = 0; i < 6; i++) begin
                    if (key_code[i] == int'(bus.ps2_key[8:0])) model_keys[i] = bus.ps2_key[9];
                end
            end
            m_old_tog = bus.ps2_key[10];
        end
        m_cyc++;
    end

    // Compare both button vectors against the model.
    task automatic checkOutput(input string tag);
        compared++;
        assert (bus.btn_p1 === exp_p1) else begin
            mismatched++;
            $error("[TB] FAIL %s btn_p1 got %b expected %b", tag, bus.btn_p1, exp_p1);
        end
        compared++;
        assert (bus.btn_p2 === exp_p2) else begin
            mismatched++;
            $error("[TB] FAIL %s btn_p2 got %b expected %b", tag, bus.btn_p2, exp_p2);
        end
    endtask

    // Directed check against a value worked out from the behaviour rules.
    task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic sendKey(input logic [8:0] code, input logic pressed);
        tog_state   = ~tog_state;
        bus.ps2_key = {tog_state, pressed, code};
    endtask

    task automatic countCoin(input int n, input string tag, output int highs);
        highs = 0;
        repeat (n) begin
            tick(1, tag);
            if (bus.btn_p1[5] === 1'b1) highs++;
        end
    endtask

    task automatic waitCoinHigh(input string tag);
        int k;
        k = 0;
        while (bus.btn_p1[5] !== 1'b1 && k < 12) begin
            tick(1, tag);
            k++;
        end
        checkValue(tag, 16'(bus.btn_p1[5]), 16'd1);
    endtask

    // Random drive: key events (table or stray codes), non-toggle word changes, sparse joystick bits, mode flips, rare reset.
    task automatic applyStimulus();
        int r;
        logic [8:0] code;
        r = int'($urandom_range(0, 99));
        if (r < 30) begin
            if ($urandom_range(0, 3) == 0) code = 9'($urandom);
            else code = 9'(key_code[$urandom_range(0, 5)]);
            sendKey(code, 1'($urandom));
        end else if (r < 35) begin
            bus.ps2_key[9:0] = 10'($urandom);
        end
        if ($urandom_range(0, 9) == 0) bus.joystick_0 = 16'($urandom) & 16'h0123;
        if ($urandom_range(0, 9) == 0) bus.joystick_1 = 16'($urandom) & 16'h0123;
        if ($urandom_range(0, 19) == 0) bus.cocktail = ~bus.cocktail;
        if ($urandom_range(0, 19) == 0) bus.autofire_on = ~bus.autofire_on;
        rst = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        int highs;
`ifdef AUTOFIRE_EN
        logic [15:0] af_got;
        logic [15:0] af_want;
`endif
        rst             = 1'b1;
        tog_state       = 1'b1;
        bus.ps2_key     = {1'b1, 1'b1, 9'h029};
        bus.joystick_0  = '0;
        bus.joystick_1  = '0;
        bus.cocktail    = 1'b0;
        bus.autofire_on = 1'b0;

        tick(3, "reset");
        checkValue("reset_p1", 16'(bus.btn_p1), 16'h0);
        checkValue("reset_p2", 16'(bus.btn_p2), 16'h0);
        rst = 1'b0;
        tick(4, "after_reset");
        checkValue("toggle_across_reset", 16'(bus.btn_p1), 16'h0);

        $display("[TB] fire key latency and hold");
        sendKey(9'h029, 1'b1);
        tick(1, "fire_press");
        checkValue("fire_lat1", 16'(bus.btn_p1[0]), 16'd0);
        tick(1, "fire_press");
        checkValue("fire_lat2", 16'(bus.btn_p1[0]), 16'd1);
        tick(20, "fire_hold");
        checkValue("fire_held", 16'(bus.btn_p1), 16'h01);
        sendKey(9'h029, 1'b0);
        tick(1, "fire_release");
        checkValue("fire_rel1", 16'(bus.btn_p1[0]), 16'd1);
        tick(1, "fire_release");
        checkValue("fire_rel2", 16'(bus.btn_p1[0]), 16'd0);

        $display("[TB] unmapped code");
        sendKey(9'h0AA, 1'b1);
        tick(3, "unmapped");
        checkValue("unmapped", 16'(bus.btn_p1), 16'h0);
        sendKey(9'h0AA, 1'b0);
        tick(2, "unmapped");

        $display("[TB] joystick routing");
        bus.joystick_1 = 16'h0002;
        tick(1, "joy_single");
        checkValue("joy1_to_p1", 16'(bus.btn_p1), 16'h08);
        checkValue("joy1_p2_off", 16'(bus.btn_p2), 16'h0);
        bus.cocktail = 1'b1;
        tick(1, "joy_cocktail");
        checkValue("cocktail_p1", 16'(bus.btn_p1), 16'h0);
        checkValue("cocktail_p2", 16'(bus.btn_p2), 16'h08);
        bus.joystick_1 = '0;
        bus.cocktail   = 1'b0;
        tick(2, "joy_clear");

        $display("[TB] coin pulse and lockout");
        sendKey(9'h021, 1'b1);
        countCoin(100, "coin_hold", highs);
        checkValue("coin_hold_pulse", 16'(highs), 16'd8);
        sendKey(9'h021, 1'b0);
        tick(3, "coin_release");
        sendKey(9'h021, 1'b1);
        waitCoinHigh("coin_start");
        tick(8, "coin_pulse");
        tick(2, "coin_gap");
        sendKey(9'h021, 1'b0);
        tick(1, "coin_gap");
        sendKey(9'h021, 1'b1);
        countCoin(30, "coin_gap_repress", highs);
        checkValue("gap_repress_ignored", 16'(highs), 16'd0);
        sendKey(9'h021, 1'b0);
        tick(3, "coin_release");
        sendKey(9'h021, 1'b1);
        countCoin(30, "coin_second", highs);
        checkValue("coin_second_pulse", 16'(highs), 16'd8);
        sendKey(9'h021, 1'b0);
        tick(3, "coin_release");

        $display("[TB] reset during coin pulse");
        sendKey(9'h021, 1'b1);
        waitCoinHigh("coin_start2");
        tick(3, "coin_pulse");
        rst = 1'b1;
        tick(1, "coin_reset");
        checkValue("reset_drop", 16'(bus.btn_p1[5]), 16'd0);
        rst = 1'b0;
        countCoin(20, "coin_after_reset", highs);
        checkValue("no_pulse_after_reset", 16'(highs), 16'd0);
        sendKey(9'h021, 1'b0);
        tick(2, "coin_release");

        rst = 1'b1;
        bus.joystick_0 = 16'h0100;
        tick(2, "coin_joy_reset");
        rst = 1'b0;
        countCoin(20, "coin_joy_held", highs);
        checkValue("held_joy_no_trigger", 16'(highs), 16'd0);
        bus.joystick_0 = '0;
        tick(2, "coin_joy_release");
        bus.joystick_0 = 16'h0100;
        countCoin(20, "coin_joy_press", highs);
        checkValue("joy_coin_pulse", 16'(highs), 16'd8);
        bus.joystick_0 = '0;
        tick(20, "coin_idle");

`ifdef AUTOFIRE_EN
        $display("[TB] autofire");
        bus.autofire_on = 1'b1;
        sendKey(9'h029, 1'b1);
        tick(1, "af_press");
        af_got  = '0;
        af_want = '0;
        for (int k = 0; k < 16; k++) begin
            tick(1, "af_hold");
            af_got[k]  = bus.btn_p1[0];
            af_want[k] = ((k / HALF) % 2) == 0;
        end
        checkValue("autofire_pattern", af_got, af_want);
        sendKey(9'h029, 1'b0);
        tick(2, "af_release");
        checkValue("autofire_release", 16'(bus.btn_p1[0]), 16'd0);
        bus.autofire_on = 1'b0;
`endif

        $display("[TB] randomized phase");
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            tick(1, "random");
        end
        rst = 1'b0;
        tick(30, "random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
